// File: rtl/fp32_pkg.sv
// fp32_pkg: shared constants, field widths and FSM state type for the
// fp32 arithmetic blocks (fp32add, fp32sub_seq, fp32_lzc).
package fp32_pkg;

  localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;
  localparam logic [31:0] FP32_PINF = 32'h7F80_0000;
  localparam logic [31:0] FP32_NINF = 32'hFF80_0000;
  localparam int unsigned FP32_BIAS = 127;

  localparam int unsigned EXP_W = 8;
  localparam int unsigned MAN_W = 23;
  // Extended significand: hidden bit + fraction + guard/round/sticky.
  localparam int unsigned EXT_W = MAN_W + 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ALIGN = 3'd1,
    ST_ADD   = 3'd2,
    ST_NORM  = 3'd3,
    ST_DONE  = 3'd4
  } fsm_state_e;

endpackage

// File: rtl/fp32_lzc.sv
// fp32_lzc: combinational leading-zero counter over the 27-bit extended
// significand (hidden + 23 fraction + G/R/S).
//   value : extended significand
//   count : number of leading zeros (27 when value is zero)
module fp32_lzc
  import fp32_pkg::*;
(
  input  logic [EXT_W-1:0] value,
  output logic [4:0]       count
);

  always_comb begin
    count = 5'(EXT_W);
    // Ascending scan: the highest set bit is the last one to win.
    for (int unsigned i = 0; i < EXT_W; i++) begin
      if (value[i]) count = 5'(EXT_W - 1 - i);
    end
  end

endmodule

// File: rtl/fp32sub_seq.sv
// fp32sub_seq: multi-cycle IEEE-754 single-precision subtractor, result = a - b.
// Denormals flush to zero, round to nearest even, canonical quiet NaN.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : operand handshake (a minuend, b subtrahend)
//   out_valid / out_ready: result handshake, result held until accepted
module fp32sub_seq
  import fp32_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result
);

  fsm_state_e        state_q, state_d;
  logic [31:0]       opa_q, opa_d, opb_q, opb_d;
  logic              sign_q, sign_d, eff_sub_q, eff_sub_d;
  logic [EXP_W-1:0]  exp_q, exp_d;
  logic [EXT_W-1:0]  man_l_q, man_l_d, man_s_q, man_s_d;
  logic              special_q, special_d;
  logic [31:0]       spec_val_q, spec_val_d;
  logic [EXT_W:0]    sum_q, sum_d;
  logic [EXT_W-1:0]  norm_q, norm_d;
  logic signed [9:0] nexp_q, nexp_d;
  logic              rnd_q, rnd_d;
  logic [31:0]       result_q, result_d;

  logic [EXP_W-1:0]  exp_a, exp_b, exp_s, diff;
  logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, swap, up;
  logic [EXT_W-1:0]  ext_a, ext_b, raw_s, shifted, mask;
  logic [MAN_W+1:0]  mant;
  logic signed [9:0] rexp;
  logic [4:0]        lz;

  fp32_lzc u_lzc (
    .value (sum_q[EXT_W-1:0]),
    .count (lz)
  );

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;

  always_comb begin
    state_d    = state_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    sign_d     = sign_q;
    eff_sub_d  = eff_sub_q;
    exp_d      = exp_q;
    man_l_d    = man_l_q;
    man_s_d    = man_s_q;
    special_d  = special_q;
    spec_val_d = spec_val_q;
    sum_d      = sum_q;
    norm_d     = norm_q;
    nexp_d     = nexp_q;
    rnd_d      = rnd_q;
    result_d   = result_q;

    exp_a   = opa_q[30:23];
    exp_b   = opb_q[30:23];
    a_nan   = (exp_a == '1) && (opa_q[22:0] != '0);
    b_nan   = (exp_b == '1) && (opb_q[22:0] != '0);
    a_inf   = (exp_a == '1) && (opa_q[22:0] == '0);
    b_inf   = (exp_b == '1) && (opb_q[22:0] == '0);
    a_zero  = (exp_a == '0);
    b_zero  = (exp_b == '0);
    ext_a   = a_zero ? '0 : {1'b1, opa_q[22:0], 3'b000};
    ext_b   = b_zero ? '0 : {1'b1, opb_q[22:0], 3'b000};
    swap    = (b_zero ? 31'd0 : opb_q[30:0]) > (a_zero ? 31'd0 : opa_q[30:0]);
    exp_s   = swap ? exp_a : exp_b;
    raw_s   = swap ? ext_a : ext_b;
    diff    = (swap ? exp_b : exp_a) - exp_s;
    shifted = raw_s >> diff;
    mask    = '1;
    mask    = ~(mask << diff);
    up      = norm_q[2] & (norm_q[1] | norm_q[0] | norm_q[3]);
    mant    = {1'b0, norm_q[EXT_W-1:3]} + 25'(up);
    rexp    = nexp_q + $signed({9'b0, mant[MAN_W+1]});

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          opa_d   = a;
          opb_d   = {~b[31], b[30:0]};
          state_d = ST_ALIGN;
        end
      end
      ST_ALIGN: begin
        sign_d    = swap ? opb_q[31] : opa_q[31];
        exp_d     = swap ? exp_b : exp_a;
        man_l_d   = swap ? ext_b : ext_a;
        eff_sub_d = opa_q[31] ^ opb_q[31];
        if (diff >= 8'd26) man_s_d = {{(EXT_W-1){1'b0}}, |raw_s};
        else               man_s_d = {shifted[EXT_W-1:1], shifted[0] | (|(raw_s & mask))};
        special_d  = 1'b1;
        spec_val_d = '0;
        if (a_nan || b_nan)       spec_val_d = FP32_QNAN;
        else if (a_inf && b_inf)  spec_val_d = eff_sub_d ? FP32_QNAN : opa_q;
        else if (a_inf)           spec_val_d = opa_q;
        else if (b_inf)           spec_val_d = opb_q;
        else if (a_zero && b_zero) spec_val_d = {opa_q[31] & opb_q[31], 31'd0};
        else                      special_d = 1'b0;
        state_d = ST_ADD;
      end
      ST_ADD: begin
        if (eff_sub_q) sum_d = {1'b0, man_l_q} - {1'b0, man_s_q};
        else           sum_d = {1'b0, man_l_q} + {1'b0, man_s_q};
        rnd_d   = 1'b0;
        state_d = ST_NORM;
      end
      ST_NORM: begin
        // NORM spans two cycles: normalise first, then round and register the
        // final word, keeping the shifter and the rounding adder on separate paths.
        if (!rnd_q) begin
          if (sum_q[EXT_W]) begin
            norm_d = {sum_q[EXT_W:2], sum_q[1] | sum_q[0]};
            nexp_d = $signed({2'b00, exp_q}) + 10'sd1;
          end else begin
            norm_d = sum_q[EXT_W-1:0] << lz;
            nexp_d = $signed({2'b00, exp_q}) - $signed({5'b00000, lz});
          end
          rnd_d = 1'b1;
        end else begin
          if (special_q)              result_d = spec_val_q;
          else if (norm_q == '0)      result_d = '0;
          else if (nexp_q <= 10'sd0)  result_d = {sign_q, 31'd0};
          else if (rexp >= 10'sd255)  result_d = sign_q ? FP32_NINF : FP32_PINF;
          else if (mant[MAN_W+1])     result_d = {sign_q, rexp[7:0], mant[MAN_W:1]};
          else                        result_d = {sign_q, rexp[7:0], mant[MAN_W-1:0]};
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      opa_q      <= '0;
      opb_q      <= '0;
      sign_q     <= 1'b0;
      eff_sub_q  <= 1'b0;
      exp_q      <= '0;
      man_l_q    <= '0;
      man_s_q    <= '0;
      special_q  <= 1'b0;
      spec_val_q <= '0;
      sum_q      <= '0;
      norm_q     <= '0;
      nexp_q     <= '0;
      rnd_q      <= 1'b0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      sign_q     <= sign_d;
      eff_sub_q  <= eff_sub_d;
      exp_q      <= exp_d;
      man_l_q    <= man_l_d;
      man_s_q    <= man_s_d;
      special_q  <= special_d;
      spec_val_q <= spec_val_d;
      sum_q      <= sum_d;
      norm_q     <= norm_d;
      nexp_q     <= nexp_d;
      rnd_q      <= rnd_d;
      result_q   <= result_d;
    end
  end

endmodule

// File: tb/tb_fp32sub_seq.sv
// tb_fp32sub_seq: self-checking bench for fp32sub_seq. An exact wide-integer
// reference model predicts every result; a per-cycle monitor checks the
// handshake timing and the result against the model.
module tb_fp32sub_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp32sub_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %08h, expected %08h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Exact reference: both operands become integers on a common scale, the
  // difference is formed exactly, then rounded once to 24 bits (nearest even).
  function automatic logic [31:0] model_sub(input logic [31:0] x, input logic [31:0] y);
    logic         sx, sy, zx, zy, s, up;
    int           ex, ey, emin, msb, e, sh;
    logic [287:0] ax, ay, mag, keep, rem, half;
    sx = x[31];
    sy = ~y[31];
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    if ((ex == 255 && x[22:0] != 0) || (ey == 255 && y[22:0] != 0)) return 32'h7FC00000;
    if (ex == 255 && ey == 255) return (sx == sy) ? {sx, 8'hFF, 23'h0} : 32'h7FC00000;
    if (ex == 255) return {sx, 8'hFF, 23'h0};
    if (ey == 255) return {sy, 8'hFF, 23'h0};
    zx = (ex == 0);
    zy = (ey == 0);
    if (zx && zy) return {sx & sy, 31'h0};
    emin = zx ? ey : (zy ? ex : ((ex < ey) ? ex : ey));
    ax = zx ? '0 : (288'({1'b1, x[22:0]}) << (ex - emin));
    ay = zy ? '0 : (288'({1'b1, y[22:0]}) << (ey - emin));
    if (sx == sy)      begin mag = ax + ay; s = sx; end
    else if (ax >= ay) begin mag = ax - ay; s = sx; end
    else               begin mag = ay - ax; s = sy; end
    if (mag == '0) return 32'h0;
    msb = 0;
    for (int i = 0; i < 288; i++) if (mag[i]) msb = i;
    e = msb + emin - 23;
    if (e <= 0) return {s, 31'h0};
    if (msb > 23) begin
      sh   = msb - 23;
      keep = mag >> sh;
      rem  = mag - (keep << sh);
      half = 288'(1) << (sh - 1);
      up   = (rem > half) || ((rem == half) && keep[0]);
      keep = keep + 288'(up);
    end else begin
      keep = mag << (23 - msb);
    end
    if (keep[24]) begin
      keep = keep >> 1;
      e++;
    end
    if (e >= 255) return s ? 32'hFF800000 : 32'h7F800000;
    return {s, 8'(e), keep[22:0]};
  endfunction

  // Per-cycle monitor: bench-side view of the transaction timing.
  logic        busy = 1'b0;
  int          age = 0;
  logic [31:0] expq[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_result", result, 32'd0);
      busy = 1'b0;
      age  = 0;
      expq.delete();
    end else begin
      chk("in_ready", {31'd0, in_ready}, {31'd0, !busy});
      chk("out_valid", {31'd0, out_valid}, {31'd0, busy && (age >= 4)});
      if (busy && age >= 4 && out_valid && expq.size() > 0) chk("result", result, expq[0]);
      if (!busy) begin
        if (in_valid) begin
          busy = 1'b1;
          age  = 0;
          expq.push_back(model_sub(a, b));
        end
      end else if (age >= 4 && out_ready) begin
        busy = 1'b0;
        if (expq.size() > 0) void'(expq.pop_front());
      end else begin
        age++;
      end
    end
  end

  task automatic run_op(input logic [31:0] x, input logic [31:0] y, input int stall,
                        output logic [31:0] got);
    int          n;
    logic [31:0] held;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("accept_ready", {31'd0, in_ready}, 32'd1);
    a = x;
    b = y;
    in_valid  = 1'b1;
    out_ready = (stall == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
    n = 0;
    while (!out_valid && n < 12) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", 32'(n), 32'd4);
    held = result;
    for (int k = 0; k < stall; k++) begin
      in_valid = 1'b1;
      a = $urandom;
      b = $urandom;
      @(posedge clk); #1;
      chk("stall_result", result, held);
      chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    got = result;
    @(posedge clk); #1;
    chk("ready_after_done", {31'd0, in_ready}, 32'd1);
  endtask

  logic [31:0] dir_a [11] = '{32'h40400000, 32'h40400000, 32'h3F800000, 32'h80000000,
                              32'h00000000, 32'h7F800000, 32'h7FC00000, 32'h40400000,
                              32'h4B800000, 32'h3F800000, 32'h7F7FFFFF};
  logic [31:0] dir_b [11] = '{32'hC0800000, 32'h40000000, 32'h3F800000, 32'h00000000,
                              32'h00000000, 32'h7F800000, 32'h40400000, 32'h7F800000,
                              32'hBF800000, 32'h33800000, 32'hFF7FFFFF};
  logic [31:0] dir_r [11] = '{32'h40E00000, 32'h3F800000, 32'h00000000, 32'h80000000,
                              32'h00000000, 32'h7FC00000, 32'h7FC00000, 32'hFF800000,
                              32'h4B800000, 32'h3F7FFFFF, 32'h7F800000};

  initial begin
    logic [31:0] got, x, y;
    int          ea, eb, mode;

    // Pin the model to hand-computed values.
    chk("model_3_minus_neg4", model_sub(32'h40400000, 32'hC0800000), 32'h40E00000);
    chk("model_tie_even", model_sub(32'h4B800000, 32'hBF800000), 32'h4B800000);
    chk("model_exact", model_sub(32'h3F800000, 32'h33800000), 32'h3F7FFFFF);
    chk("model_neg_zero", model_sub(32'h80000000, 32'h00000000), 32'h80000000);
    chk("model_inf_inf", model_sub(32'h7F800000, 32'h7F800000), 32'h7FC00000);

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      run_op(dir_a[i], dir_b[i], 0, got);
      chk($sformatf("directed%0d", i), got, dir_r[i]);
    end

    // Backpressure: result held for 6 stalled cycles, new operands refused.
    run_op(32'h40400000, 32'h40000000, 6, got);
    chk("backpressure_result", got, 32'h3F800000);

    // Reset while in NORM (two edges after accept).
    a = 32'h40400000;
    b = 32'h40000000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_result", result, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_op(32'h40400000, 32'hC0800000, 0, got);
    chk("after_reset", got, 32'h40E00000);

    for (int i = 0; i < 300; i++) begin
      mode = int'($urandom_range(0, 3));
      ea   = int'($urandom_range(1, 254));
      x    = {1'($urandom), 8'(ea), 23'($urandom)};
      case (mode)
        0: begin
          x = $urandom;
          y = $urandom;
        end
        1: begin
          eb = ea + int'($urandom_range(0, 60)) - 30;
          if (eb < 1) eb = 1;
          if (eb > 254) eb = 254;
          y = {1'($urandom), 8'(eb), 23'($urandom)};
        end
        2: y = x ^ {1'($urandom), 8'h00, 23'($urandom_range(0, 3))};
        default: begin
          x[30:23] = 8'($urandom_range(248, 254));
          y = {1'($urandom), 8'($urandom_range(248, 254)), 23'($urandom)};
        end
      endcase
      run_op(x, y, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0, got);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1);
  end

endmodule
